pulse_meter: RTL and testbench

PULSE_METER -- requirements
Module: pulse_meter

---
 rtl/pulse_meter_if.sv | 22 ++
 rtl/pulse_meter.sv | 185 ++++++++++++++++++
 tb/tb_pulse_meter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pulse_meter_if.sv
// Measurement handshake between pulse_meter (master) and its consumer (slave).
interface pulse_meter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] high_len;
    logic [WIDTH-1:0] low_len;
    logic [WIDTH:0]   period;
    logic             sat;
    logic             valid;
    logic             ack;
    logic             overrun;

    modport master (
        output high_len, low_len, period, sat, valid, overrun,
        input  ack
    );

    modport slave (
        input  high_len, low_len, period, sat, valid, overrun,
        output ack
    );
endinterface

// File: rtl/pulse_meter.sv
// Measures high/low phase lengths of a pulse train and hands each completed period
// to a consumer with valid/ack. Define PULSE_METER_SYNC_EN to add a 2-flop input synchronizer.
module pulse_meter #(
    parameter int WIDTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          signal,
    pulse_meter_if.master meas
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] high;
        logic [WIDTH-1:0] low;
        logic             sat;
    } snap_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic sig_in;

`ifdef PULSE_METER_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = signal;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sig_in = sync2_q;
`else
    assign sig_in = signal;
`endif

    // Edge detection
    logic s_cur_q, s_cur_d;
    logic s_prev_q, s_prev_d;
    logic rise, fall;

    always_comb begin
        s_cur_d  = sig_in;
        s_prev_d = s_cur_q;
    end

    assign rise = s_cur_q & ~s_prev_q;
    assign fall = ~s_cur_q & s_prev_q;

    // Phase FSM and counters
    state_e           state_q, state_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic             psat_q, psat_d;
    logic             cap_q, cap_d;
    snap_t            snap_q, snap_d;

    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        psat_d  = psat_q;
        cap_d   = 1'b0;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                high_d = '0;
                low_d  = '0;
                psat_d = 1'b0;
                if (rise) begin
                    state_d = HIGH;
                    high_d  = CNT_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    low_d   = CNT_ONE;
                end else if (s_cur_q) begin
                    if (high_q == CNT_MAX) psat_d = 1'b1;
                    else                   high_d = high_q + CNT_ONE;
                end
            end
            LOW: begin
                if (rise) begin
                    // Period complete: snapshot now, publish to outputs next cycle
                    cap_d       = 1'b1;
                    snap_d.high = high_q;
                    snap_d.low  = low_q;
                    snap_d.sat  = psat_q;
                    state_d     = HIGH;
                    high_d      = CNT_ONE;
                    low_d       = '0;
                    psat_d      = 1'b0;
                end else if (!s_cur_q) begin
                    if (low_q == CNT_MAX) psat_d = 1'b1;
                    else                  low_d  = low_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers and handshake
    logic [WIDTH-1:0] high_len_q, high_len_d;
    logic [WIDTH-1:0] low_len_q, low_len_d;
    logic [WIDTH:0]   period_q, period_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        high_len_d = high_len_q;
        low_len_d  = low_len_q;
        period_d   = period_q;
        sat_d      = sat_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        if (valid_q && meas.ack) valid_d = 1'b0;
        if (cap_q) begin
            // A result still waiting for ack is kept; the new one is dropped
            if (!valid_q || meas.ack) begin
                high_len_d = snap_q.high;
                low_len_d  = snap_q.low;
                period_d   = {1'b0, snap_q.high} + {1'b0, snap_q.low};
                sat_d      = snap_q.sat;
                valid_d    = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s_cur_q    <= 1'b0;
            s_prev_q   <= 1'b0;
            state_q    <= IDLE;
            high_q     <= '0;
            low_q      <= '0;
            psat_q     <= 1'b0;
            cap_q      <= 1'b0;
            snap_q     <= '0;
            high_len_q <= '0;
            low_len_q  <= '0;
            period_q   <= '0;
            sat_q      <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            s_cur_q    <= s_cur_d;
            s_prev_q   <= s_prev_d;
            state_q    <= state_d;
            high_q     <= high_d;
            low_q      <= low_d;
            psat_q     <= psat_d;
            cap_q      <= cap_d;
            snap_q     <= snap_d;
            high_len_q <= high_len_d;
            low_len_q  <= low_len_d;
            period_q   <= period_d;
            sat_q      <= sat_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign meas.high_len = high_len_q;
    assign meas.low_len  = low_len_q;
    assign meas.period   = period_q;
    assign meas.sat      = sat_q;
    assign meas.valid    = valid_q;
    assign meas.overrun  = overrun_q;
endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: latency, square waves, saturation, overrun, reset, ack/capture collision.
module tb_pulse_meter;
`ifdef PULSE_METER_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clock;
    logic reset;
    logic signal;
    int   vectors;
    int   miscompares;

    pulse_meter_if #(.WIDTH(8)) mif ();

    pulse_meter #(.WIDTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .signal (signal),
        .meas   (mif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic s);
        signal = s;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic period_wave(input int hi, input int lo);
        repeat (hi) tick(1'b1);
        repeat (lo) tick(1'b0);
    endtask

    task automatic chk_meas(input string tag, input int h, input int l, input int p,
                            input int s, input int v, input int o);
        chk({tag, ".high_len"}, 32'(mif.high_len), 32'(h));
        chk({tag, ".low_len"},  32'(mif.low_len),  32'(l));
        chk({tag, ".period"},   32'(mif.period),   32'(p));
        chk({tag, ".sat"},      32'(mif.sat),      32'(s));
        chk({tag, ".valid"},    32'(mif.valid),    32'(v));
        chk({tag, ".overrun"},  32'(mif.overrun),  32'(o));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        signal      = 1'b0;
        mif.ack     = 1'b0;
        @(negedge clock);

        // reset state, and outputs held while reset asserted
        tick(1'b0);
        chk_meas("rst", 0, 0, 0, 0, 0, 0);
        mif.ack = 1'b1;
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        chk_meas("rst_hold", 0, 0, 0, 0, 0, 0);

        // 5 high / 15 low, exact valid latency after completing rise
        do_reset();
        mif.ack = 1'b1;
        period_wave(5, 15);
        tick(1'b1);
        chk("lat.k0.valid", 32'(mif.valid), 32'd0);
        for (int i = 1; i < LAT; i++) begin
            tick(1'b1);
            chk("lat.pre.valid", 32'(mif.valid), 32'd0);
        end
        tick(1'b1);
        chk_meas("lat", 5, 15, 20, 0, 1, 0);
        tick(1'b1);
        chk("lat.ackd.valid", 32'(mif.valid), 32'd0);

        // 4/4 square wave, ack tied high
        do_reset();
        mif.ack = 1'b1;
        period_wave(4, 4);
        period_wave(4, 4);
        period_wave(4, 4);
        chk_meas("sq1", 4, 4, 8, 0, 0, 0);
        period_wave(4, 4);
        chk_meas("sq2", 4, 4, 8, 0, 0, 0);

        // saturation: 300 high / 2 low, then a clean 3/3 period
        do_reset();
        mif.ack = 1'b1;
        period_wave(300, 2);
        period_wave(3, 3);
        chk_meas("sat", 255, 2, 257, 1, 0, 0);
        period_wave(3, 3);
        chk_meas("sat_clr", 3, 3, 6, 0, 0, 0);

        // overrun: ack held low across two periods
        do_reset();
        mif.ack = 1'b0;
        period_wave(4, 4);
        period_wave(6, 6);
        chk_meas("ovr.first", 4, 4, 8, 0, 1, 0);
        repeat (LAT + 1) tick(1'b1);
        chk_meas("ovr.drop", 4, 4, 8, 0, 1, 1);
        mif.ack = 1'b1;
        tick(1'b1);
        mif.ack = 1'b0;
        chk("ovr.ack.valid", 32'(mif.valid), 32'd0);
        chk("ovr.ack.overrun", 32'(mif.overrun), 32'd1);

        // reset pulse during HIGH discards partial period
        do_reset();
        mif.ack = 1'b0;
        period_wave(6, 6);
        repeat (LAT + 3) tick(1'b1);
        chk_meas("mid.pre", 6, 6, 12, 0, 1, 0);
        reset = 1'b0;
        tick(1'b1);
        reset = 1'b1;
        chk_meas("mid.rst", 0, 0, 0, 0, 0, 0);
        repeat (3) tick(1'b0);
        mif.ack = 1'b1;
        period_wave(4, 4);
        chk_meas("mid.none", 0, 0, 0, 0, 0, 0);
        period_wave(4, 4);
        chk_meas("mid.next", 4, 4, 8, 0, 0, 0);

        // capture coincident with ack while valid
        do_reset();
        mif.ack = 1'b0;
        period_wave(4, 4);
        period_wave(6, 6);
        chk_meas("coll.pre", 4, 4, 8, 0, 1, 0);
        tick(1'b1);
        for (int i = 1; i < LAT; i++) tick(1'b1);
        mif.ack = 1'b1;
        tick(1'b1);
        mif.ack = 1'b0;
        chk_meas("coll", 6, 6, 12, 0, 1, 0);
        tick(1'b1);
        chk("coll.hold.valid", 32'(mif.valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
